multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Main control FSM for a multi-cycle MIPS-style datapath.
// Datapath strobes are decoded from the current state, with memReady stalling the memory states.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSrc,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       instrDone,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYP = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ANDIEX = 4'd10,
    S_ITWB   = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       pc_write_c;
  logic       pc_write_cond_c;
  logic [1:0] pc_src_c;
  logic       iord_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       reg_write_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic       instr_done_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state strobe decode
  always_comb begin
    state_d         = S_FETCH;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_src_c        = PC_ALU;
    iord_c          = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = SRCB_B;
    alu_op_c        = ALU_ADD;
    instr_done_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        ir_write_c  = memReady;
        pc_write_c  = memReady;
        state_d     = memReady ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        alu_src_b_c = SRCB_IMM4;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Unknown opcode retires here and refetches
            state_d      = S_FETCH;
            instr_done_c = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        state_d    = memReady ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        mem_write_c  = 1'b1;
        iord_c       = 1'b1;
        instr_done_c = memReady;
        state_d      = memReady ? S_FETCH : S_MEMWR;
      end

      S_RTEX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_FUNC;
        state_d     = S_RTWB;
      end

      S_RTWB: begin
        reg_dst_c    = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_BEQ: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = ALU_SUB;
        pc_write_cond_c = 1'b1;
        pc_src_c        = PC_ALUOUT;
        instr_done_c    = 1'b1;
        state_d         = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = S_ITWB;
      end

      S_ANDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALU_AND;
        state_d     = S_ITWB;
      end

      S_ITWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_src_c     = PC_JUMP;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every strobe quiet, independent of the state register
  assign pcWrite     = pc_write_c & ~rst;
  assign pcWriteCond = pc_write_cond_c & ~rst;
  assign pcSrc       = rst ? 2'b00 : pc_src_c;
  assign iorD        = iord_c & ~rst;
  assign memRead     = mem_read_c & ~rst;
  assign memWrite    = mem_write_c & ~rst;
  assign irWrite     = ir_write_c & ~rst;
  assign regDst      = reg_dst_c & ~rst;
  assign memToReg    = mem_to_reg_c & ~rst;
  assign regWrite    = reg_write_c & ~rst;
  assign aluSrcA     = alu_src_a_c & ~rst;
  assign aluSrcB     = rst ? 2'b00 : alu_src_b_c;
  assign aluOp       = rst ? 2'b00 : alu_op_c;
  assign instrDone   = instr_done_c & ~rst;
  assign state       = ST_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized instruction-level bench for multi_cycle_controller.
// Expected state traces come from per-instruction phase lists; strobes come from the per-state table.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, instrDone;
  logic [1:0] pcSrc, aluSrcB, aluOp;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       instrDone;
  } ctl_t;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
    .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .instrDone(instrDone), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c = '{pcWrite, pcWriteCond, pcSrc, iorD, memRead, memWrite, irWrite,
          regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, instrDone};
    return c;
  endfunction

  // Strobe table: one row per state
  function automatic ctl_t expected(input int s, input logic mr, input logic illegal);
    ctl_t c;
    c = '0;
    case (s)
      0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = mr; c.pcWrite = mr; end
      1:  begin c.aluSrcB = 2'b11; c.instrDone = illegal; end
      2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      3:  begin c.memRead = 1; c.iorD = 1; end
      4:  begin c.memToReg = 1; c.regWrite = 1; c.instrDone = 1; end
      5:  begin c.memWrite = 1; c.iorD = 1; c.instrDone = mr; end
      6:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      7:  begin c.regDst = 1; c.regWrite = 1; c.instrDone = 1; end
      8:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSrc = 2'b01; c.instrDone = 1; end
      9:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      10: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluOp = 2'b11; end
      11: begin c.regWrite = 1; c.instrDone = 1; end
      12: begin c.pcWrite = 1; c.pcSrc = 2'b10; c.instrDone = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  int done_seen;
  int cyc_to_done;

  // One cycle: drive after the edge, check at the falling edge
  task automatic run_cycle(input int es, input logic mr, input logic illegal, input string tag);
    memReady = mr;
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".ctl"}, 32'(observed()), 32'(expected(es, mr, illegal)));
    chk({tag, ".excl"}, 32'(int'(regWrite) + int'(memWrite) + int'(pcWrite) <= 1), 32'd1);
    chk({tag, ".range"}, 32'(state <= 4'd12), 32'd1);
    if (done_seen == 0) cyc_to_done++;
    if (instrDone) done_seen++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b001100, 6'b000010};
  endfunction

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b001100: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Run one whole instruction with given fetch and memory wait counts
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    int q_s[$];
    logic q_m[$];
    logic ill;
    string tag;
    ill = !is_legal(op);
    opcode = op;
    for (int i = 0; i < wf; i++) begin q_s.push_back(0); q_m.push_back(1'b0); end
    q_s.push_back(0); q_m.push_back(1'b1);
    q_s.push_back(1); q_m.push_back(1'($urandom));
    case (op)
      6'b100011: begin
        q_s.push_back(2); q_m.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin q_s.push_back(3); q_m.push_back(1'b0); end
        q_s.push_back(3); q_m.push_back(1'b1);
        q_s.push_back(4); q_m.push_back(1'($urandom));
      end
      6'b101011: begin
        q_s.push_back(2); q_m.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin q_s.push_back(5); q_m.push_back(1'b0); end
        q_s.push_back(5); q_m.push_back(1'b1);
      end
      6'b000000: begin q_s.push_back(6); q_s.push_back(7); q_m.push_back(1'($urandom)); q_m.push_back(1'($urandom)); end
      6'b000100: begin q_s.push_back(8); q_m.push_back(1'($urandom)); end
      6'b001000: begin q_s.push_back(9); q_s.push_back(11); q_m.push_back(1'($urandom)); q_m.push_back(1'($urandom)); end
      6'b001100: begin q_s.push_back(10); q_s.push_back(11); q_m.push_back(1'($urandom)); q_m.push_back(1'($urandom)); end
      6'b000010: begin q_s.push_back(12); q_m.push_back(1'($urandom)); end
      default: ;
    endcase
    done_seen = 0;
    cyc_to_done = 0;
    tag = $sformatf("op%02h", op);
    foreach (q_s[i]) run_cycle(q_s[i], q_m[i], ill, tag);
    chk({tag, ".done_cnt"}, 32'(done_seen), 32'd1);
    chk({tag, ".cycles"}, 32'(cyc_to_done),
        32'(base_cycles(op) + wf + ((op == 6'b100011 || op == 6'b101011) ? wm : 0)));
  endtask

  // Reset while waiting in a memory state (3 = MEMRD, 5 = MEMWR)
  task automatic reset_mid(input logic [5:0] op, input int ws);
    done_seen = 0;
    cyc_to_done = 0;
    opcode = op;
    run_cycle(0, 1'b1, 1'b0, "rm.fetch");
    run_cycle(1, 1'b1, 1'b0, "rm.decode");
    run_cycle(2, 1'b1, 1'b0, "rm.memadr");
    run_cycle(ws, 1'b0, 1'b0, "rm.wait");
    rst = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    chk("rm.rst_state_before", 32'(state), 32'(ws));
    chk("rm.rst_ctl_zero", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rm.rst_state_after", 32'(state), 32'd0);
    chk("rm.rst_ctl_zero2", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rm.post_memread", 32'(memRead), 32'd1);
    chk("rm.post_state", 32'(state), 32'd0);
    // Complete a fetch so the next instruction starts cleanly
    @(posedge clk);
    #1;
    run_cycle(1, 1'b0, 1'b0, "rm.redecode");
    case (op)
      6'b100011: begin run_cycle(2, 1'b1, 1'b0, "rm.a"); run_cycle(3, 1'b1, 1'b0, "rm.b"); run_cycle(4, 1'b1, 1'b0, "rm.c"); end
      default:   begin run_cycle(2, 1'b1, 1'b0, "rm.a"); run_cycle(5, 1'b1, 1'b0, "rm.b"); end
    endcase
  endtask

  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001100, 6'b000010};
    rst = 1'b1;
    memReady = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.ctl_zero", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed: the listed scenarios with no and with explicit waits
    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 1, 0);
    run_instr(6'b001100, 0, 0);
    reset_mid(6'b100011, 3);
    reset_mid(6'b101011, 5);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
